// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Pure definitions; no state.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_width(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  // Low bit of lane `port` in a packed multi-port bus of `width`-bit lanes.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

  function automatic int port_hi(input int port, input int width);
    return port * width + width - 1;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, x0 forcing and optional write bypass.
// Zero latency; wr1 beats wr0 when both bypass to the same address.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic [XLEN-1:0]  i_regs [NREGS],
  input  logic [NREGS-1:0] i_busy,
  input  logic [AW-1:0]    i_addr,
  input  logic             i_wr0_en,
  input  logic [AW-1:0]    i_wr0_addr,
  input  logic [XLEN-1:0]  i_wr0_data,
  input  logic             i_wr1_en,
  input  logic [AW-1:0]    i_wr1_addr,
  input  logic [XLEN-1:0]  i_wr1_data,
  output logic [XLEN-1:0]  o_data,
  output logic             o_busy
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = (BYPASS != 0) && i_wr0_en && (i_wr0_addr == i_addr);
  assign w_hit1 = (BYPASS != 0) && i_wr1_en && (i_wr1_addr == i_addr);

  // A same-cycle alloc is deliberately not bypassed into o_busy.
  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (i_addr != '0) begin
      o_data = i_regs[i_addr];
      o_busy = i_busy[i_addr];
      if (w_hit1) begin
        o_data = i_wr1_data;
        o_busy = 1'b0;
      end else if (w_hit0) begin
        o_data = i_wr0_data;
        o_busy = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-write, NRD-read register file with per-register busy scoreboard and busy counter.
// Writes land in 1 cycle; busy_count is the registered popcount of the updated busy bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [AW:0]         busy_count
);

  localparam int CW = AW + 1;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_busy_count;
  logic [NREGS-1:0] w_busy_nxt;
  logic [CW-1:0]    w_busy_pop;
  logic             w_wr0_vld;
  logic             w_wr1_vld;

  assign w_wr0_vld = wr0_en && (wr0_addr != '0);
  assign w_wr1_vld = wr1_en && (wr1_addr != '0);

  // Alloc beats flush beats writeback clear; x0 is never busy.
  always_comb begin
    w_busy_nxt    = r_busy;
    w_busy_nxt[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (alloc_en && (alloc_addr == AW'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (flush) begin
        w_busy_nxt[r] = 1'b0;
      end else if ((wr0_en && (wr0_addr == AW'(r))) || (wr1_en && (wr1_addr == AW'(r)))) begin
        w_busy_nxt[r] = 1'b0;
      end
    end
  end

  always_comb begin
    w_busy_pop = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_busy_pop = w_busy_pop + CW'(w_busy_nxt[r]);
    end
  end

  // wr1 is issued after wr0 in this block so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_pop;
      if (w_wr0_vld) begin
        r_regs[wr0_addr] <= wr0_data;
      end
      if (w_wr1_vld) begin
        r_regs[wr1_addr] <= wr1_data;
      end
    end
  end

  assign busy_count = r_busy_count;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
    ) u_rd_port (
      .i_regs     (r_regs),
      .i_busy     (r_busy),
      .i_addr     (rd_addr[port_hi(k, AW):port_lo(k, AW)]),
      .i_wr0_en   (wr0_en),
      .i_wr0_addr (wr0_addr),
      .i_wr0_data (wr0_data),
      .i_wr1_en   (wr1_en),
      .i_wr1_addr (wr1_addr),
      .i_wr1_data (wr1_data),
      .o_data     (rd_data[port_hi(k, XLEN):port_lo(k, XLEN)]),
      .o_busy     (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives a bypassing and a non-bypassing instance in lockstep against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic                wr0_en, wr1_en, alloc_en, flush;
  logic [AW-1:0]       wr0_addr, wr1_addr, alloc_addr;
  logic [XLEN-1:0]     wr0_data, wr1_data;
  logic [AW:0]         cnt_b, cnt_n;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              m_cnt;
  int              n_checks = 0;
  int              n_errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_count(cnt_b)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_count(cnt_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    wr0_addr = '0; wr1_addr = '0; alloc_addr = '0; wr0_data = '0; wr1_data = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Expected read of one port: stored model state, optionally overlaid by same-cycle writes.
  task automatic check_reads();
    for (int k = 0; k < NRD; k++) begin
      int a;
      bit h0, h1;
      logic [XLEN-1:0] ed_b, ed_n;
      bit eb_b, eb_n;
      a  = int'(rd_addr[k*AW +: AW]);
      h0 = (wr0_en === 1'b1) && (int'(wr0_addr) == a);
      h1 = (wr1_en === 1'b1) && (int'(wr1_addr) == a);
      if (a == 0) begin
        ed_b = '0; ed_n = '0; eb_b = 1'b0; eb_n = 1'b0;
      end else begin
        ed_n = m_regs[a];
        eb_n = m_busy[a];
        ed_b = h1 ? wr1_data : (h0 ? wr0_data : m_regs[a]);
        eb_b = (h0 || h1) ? 1'b0 : m_busy[a];
      end
      chk($sformatf("rd_data_byp p%0d a%0d", k, a),   64'(rd_data_b[k*XLEN +: XLEN]), 64'(ed_b));
      chk($sformatf("rd_busy_byp p%0d a%0d", k, a),   64'(rd_busy_b[k]), 64'(eb_b));
      chk($sformatf("rd_data_nobyp p%0d a%0d", k, a), 64'(rd_data_n[k*XLEN +: XLEN]), 64'(ed_n));
      chk($sformatf("rd_busy_nobyp p%0d a%0d", k, a), 64'(rd_busy_n[k]), 64'(eb_n));
    end
  endtask

  task automatic model_update();
    if (rst === 1'b1) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        bit wh;
        wh = ((wr0_en === 1'b1) && (int'(wr0_addr) == r)) || ((wr1_en === 1'b1) && (int'(wr1_addr) == r));
        if ((alloc_en === 1'b1) && (int'(alloc_addr) == r)) m_busy[r] = 1'b1;
        else if (flush === 1'b1) m_busy[r] = 1'b0;
        else if (wh) m_busy[r] = 1'b0;
      end
      if ((wr0_en === 1'b1) && (wr0_addr != 0)) m_regs[wr0_addr] = wr0_data;
      if ((wr1_en === 1'b1) && (wr1_addr != 0)) m_regs[wr1_addr] = wr1_data;
    end
    m_cnt = 0;
    for (int r = 0; r < NREGS; r++) m_cnt += int'(m_busy[r]);
  endtask

  // Called ~2 time units after inputs change; returns 1 time unit after the edge.
  task automatic tick(input bit do_rd = 1'b1);
    if (do_rd) check_reads();
    @(posedge clk);
    model_update();
    #1;
    chk("busy_count_byp", 64'(cnt_b), 64'(m_cnt));
    chk("busy_count_nobyp", 64'(cnt_n), 64'(m_cnt));
  endtask

  function automatic int pick();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rd(0, 0);
    rst = 1'b1;
    #2;
    tick(1'b0);
    chk("reset_count", 64'(cnt_b), 64'd0);

    for (int a = 0; a < NREGS; a++) begin
      idle(); rd(a, NREGS - 1 - a); #2; tick();
    end

    // x5 write: bypass visible now, stored value next cycle.
    idle(); wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; rd(5, 0); #2;
    chk("x5_byp_same", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
    chk("x5_nobyp_same", 64'(rd_data_n[31:0]), 64'h0);
    tick();
    idle(); rd(5, 0); #2;
    chk("x5_nobyp_next", 64'(rd_data_n[31:0]), 64'hDEADBEEF);
    tick();

    idle(); wr0_en = 1'b1; wr0_addr = 0; wr0_data = 32'h1234; rd(0, 5); #2;
    chk("x0_byp_same", 64'(rd_data_b[31:0]), 64'h0);
    tick();
    idle(); rd(0, 5); #2;
    chk("x0_stored", 64'(rd_data_n[31:0]), 64'h0);
    tick();

    idle(); wr0_en = 1'b1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 7; wr1_data = 32'h22; rd(7, 7); #2;
    chk("x7_byp_wr1_wins", 64'(rd_data_b[31:0]), 64'h22);
    tick();
    idle(); rd(7, 0); #2;
    chk("x7_stored_wr1_wins", 64'(rd_data_n[31:0]), 64'h22);
    tick();

    idle(); alloc_en = 1'b1; alloc_addr = 3; #2; tick(); chk("alloc_cnt1", 64'(cnt_b), 64'd1);
    idle(); alloc_en = 1'b1; alloc_addr = 4; #2; tick(); chk("alloc_cnt2", 64'(cnt_b), 64'd2);
    idle(); alloc_en = 1'b1; alloc_addr = 9; #2; tick(); chk("alloc_cnt3", 64'(cnt_b), 64'd3);

    // Alloc and writeback to the same register: alloc keeps it busy.
    idle(); alloc_en = 1'b1; alloc_addr = 4; wr0_en = 1'b1; wr0_addr = 4; wr0_data = 32'h44; rd(4, 0); #2;
    tick();
    chk("wr_alloc_cnt", 64'(cnt_b), 64'd3);
    idle(); rd(4, 0); #2;
    chk("wr_alloc_busy", 64'(rd_busy_n[0]), 64'd1);
    chk("wr_alloc_data", 64'(rd_data_b[31:0]), 64'h44);
    tick();

    idle(); flush = 1'b1; #2; tick(); chk("flush_cnt0", 64'(cnt_b), 64'd0);
    idle(); alloc_en = 1'b1; alloc_addr = 3; #2; tick();
    idle(); alloc_en = 1'b1; alloc_addr = 4; #2; tick();
    idle(); #2; tick();
    idle(); #2; tick();
    chk("pre_flush_cnt2", 64'(cnt_b), 64'd2);
    idle(); flush = 1'b1; alloc_en = 1'b1; alloc_addr = 6; #2; tick();
    chk("flush_alloc_cnt1", 64'(cnt_b), 64'd1);
    idle(); rd(6, 3); #2;
    chk("flush_alloc_x6_busy", 64'(rd_busy_b[0]), 64'd1);
    chk("flush_x3_free", 64'(rd_busy_b[1]), 64'd0);
    tick();
    idle(); rd(4, 3); #2;
    chk("flush_x4_data", 64'(rd_data_n[31:0]), 64'h44);
    chk("flush_x3_data", 64'(rd_data_n[63:32]), 64'h0);
    tick();

    idle(); alloc_en = 1'b1; alloc_addr = 10; wr0_en = 1'b1; wr0_addr = 11; wr0_data = 32'h55; #2; tick();
    idle(); rst = 1'b1; wr1_en = 1'b1; wr1_addr = 11; wr1_data = 32'h99; #2; tick();
    chk("rst_cnt", 64'(cnt_b), 64'd0);
    idle(); rd(11, 10); #2;
    chk("rst_x11_data", 64'(rd_data_n[31:0]), 64'h0);
    chk("rst_x10_busy", 64'(rd_busy_n[1]), 64'd0);
    tick();

    // Undefined enable aimed at x0 must leave all state alone.
    idle(); wr0_en = 1'bx; wr0_addr = 0; wr0_data = $urandom; rd(5, 7); #2; tick();

    for (int i = 0; i < 600; i++) begin
      idle();
      rst        = ($urandom_range(0, 59) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      wr0_en     = 1'($urandom_range(0, 1));
      wr0_addr   = AW'(pick());
      wr0_data   = $urandom;
      wr1_en     = 1'($urandom_range(0, 1));
      wr1_addr   = AW'(pick());
      wr1_data   = $urandom;
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = AW'(pick());
      rd(pick(), pick());
      #2;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the pipelined core. Replaces the single-write, two-read file.
- Configurable data width, register count and read-port count.
- Two prioritised write ports: wr0 is the older instruction, wr1 the younger.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard, set at issue and cleared at writeback, plus a busy counter the hazard unit uses for stall decisions.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = read data/busy reflect same-cycle writes; 0 = reads show stored state only
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
rd_addr  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  packed read data, combinational
rd_busy  out  NRD  busy flag of each addressed register, combinational
wr0_en  in  1  write port 0 enable (older instruction)
wr0_addr  in  AW  write port 0 address
wr0_data  in  XLEN  write port 0 data
wr1_en  in  1  write port 1 enable (younger instruction)
wr1_addr  in  AW  write port 1 address
wr1_data  in  XLEN  write port 1 data
alloc_en  in  1  issue-stage allocation: mark alloc_addr busy
alloc_addr  in  AW  destination register being allocated
flush  in  1  clear all busy bits (branch mispredict); data untouched
busy_count  out  AW+1  registered count of busy registers

Behaviour:
- Reset: rst=1 at posedge clears all registers and busy bits; busy_count=0. Reset beats every other input in the same cycle. Reset mid-flight discards pending allocations.
- Register 0: hard-wired zero. Writes, allocations and busy on address 0 are ignored; reads always return 0 with busy 0, regardless of BYPASS.
- Writes: at posedge, wrN_en=1 with addr≠0 stores wrN_data. When both ports target the same address, wr1 wins.
- Write latency: 1 cycle; the stored value is visible from the next cycle.
- Busy state, per register r≠0, next value in priority order (first match wins):
  - rst → 0
  - alloc_en and alloc_addr==r → 1
  - flush → 0
  - wr0 or wr1 enabled to r → 0
  - otherwise → hold
- Consequences of the busy priority:
  - alloc overrides a same-cycle write clear; the new producer owns the register.
  - alloc overrides a same-cycle flush, because the allocating instruction is older than the flush point.
- Read bypass with BYPASS=1, per port k, addr≠0:
  - rd_data = wr1_data if wr1 hits the address; else wr0_data if wr0 hits; else the stored value.
  - rd_busy = 0 if either write hits the address; else the stored busy bit.
  - Same-cycle alloc does NOT affect rd_busy; it is visible next cycle.
- Read with BYPASS=0: rd_data and rd_busy show stored state only; a written value appears the cycle after the write.
- busy_count is a registered population count of the busy bits as updated at that edge. It is therefore consistent with the stored busy state in the following cycle.
- Range: 0..NREGS-1; never wraps, and never exceeds NREGS-1 because register 0 is never busy.
- Unknown inputs: X on an enable whose address is 0 must not corrupt state.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NREGS constants
  - AW derivation function
  - packed-port slice helper functions
- Sub-module regfile_read_port, instantiated NRD times via generate, implements one read port:
  - address mux
  - register-0 forcing
  - BYPASS priority logic

Test Plan:
- Reset, then read all addresses → rd_data=0, rd_busy=0, busy_count=0.
- Write x5=0xDEADBEEF on wr0, read x5 same cycle → BYPASS=1 gives 0xDEADBEEF; BYPASS=0 gives 0, then 0xDEADBEEF next cycle. Write 0x1234 to x0 → x0 still reads 0.
- Same cycle wr0 x7=0x11, wr1 x7=0x22, read x7 → 0x22 same cycle (BYPASS=1) and 0x22 stored.
- Alloc x3, x4, x9 on three consecutive cycles → busy_count 1,2,3. Then wr0 x4 plus alloc x4 in one cycle → x4 stays busy, count stays 3.
- Alloc x3, x4 and wait two cycles (count 2), then flush with alloc x6 in one cycle → only x6 busy, busy_count=1 next cycle, data in x3 and x4 unchanged.
- Allocate x10 and write x11=0x55, then assert rst with wr1 x11=0x99 in the same cycle → all registers 0, busy_count=0, x11 reads 0.
